wb2axi_bridge: RTL and testbench
================================

Name: wb2axi_bridge

Overview:
Wishbone B3 classic slave to AXI4 master bridge. It converts each single Wishbone read or write cycle into one single-beat AXI4 transaction. It sits between a CPU-side Wishbone bus and an AXI4 memory/interconnect, for example an AXI block RAM. Data width is 32 bits, address width is 32 bits, and no bursts are generated.

Parameters:
AXI_ID_WIDTH, 4, width of all AXI ID fields; all issued IDs are 0.

Ports:
clk  in  1  single clock for both buses
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write-enable
wb_adr_i, wb_dat_i  in  32 each  byte address; write data
wb_sel_i  in  4  byte selects
wb_cti_i, wb_bte_i  in  3, 2  burst tags; ignored (every access is treated as classic)
wb_ack_o, wb_err_o, wb_rty_o  out  1 each  termination signals
wb_dat_o  out  32  read data
m_axi_awid, m_axi_arid  out  AXI_ID_WIDTH  constant 0
m_axi_awaddr, m_axi_araddr  out  32  {wb_adr_i[31:2],2'b00}
m_axi_awlen, m_axi_arlen  out  8  constant 0
m_axi_awsize, m_axi_arsize  out  3  constant 3'b010 (4 bytes)
m_axi_awburst, m_axi_arburst  out  2  constant 2'b01 (INCR)
m_axi_awcache, m_axi_arcache  out  4  constant 4'b0011
m_axi_awprot, m_axi_arprot  out  3  constant 0
m_axi_awqos, m_axi_arqos  out  4  constant 0
m_axi_awvalid, m_axi_wvalid, m_axi_arvalid  out  1 each  request valids
m_axi_awready, m_axi_wready, m_axi_arready  in  1 each  request readies
m_axi_wdata  out  32  captured wb_dat_i
m_axi_wstrb  out  4  captured wb_sel_i
m_axi_wlast  out  1  constant 1
m_axi_bid, m_axi_rid  in  AXI_ID_WIDTH  ignored
m_axi_bresp, m_axi_rresp  in  2 each  response codes
m_axi_bvalid, m_axi_rvalid  in  1 each  response valids
m_axi_rlast  in  1  ignored
m_axi_rdata  in  32  read data
m_axi_bready, m_axi_rready  out  1 each  response ready

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - All valids, bready, rready, wb_ack_o and wb_err_o are 0.
  - wb_dat_o, address, wdata and wstrb registers are 0.
- wb_rty_o is always 0.
- States: IDLE, WRITE_REQ, WRITE_RESP, READ_REQ, READ_RESP, DONE.
- IDLE, when cyc&stb=1:
  - Register the word-aligned address.
  - If we=1: register wdata and wstrb, set awvalid=1 and wvalid=1, go to WRITE_REQ.
  - Else: set arvalid=1, go to READ_REQ.
- WRITE_REQ:
  - Each valid drops on the cycle after its own valid&ready handshake; AW and W are tracked independently.
  - When both channels have handshaked, go to WRITE_RESP with bready=1.
- WRITE_RESP, on bvalid:
  - Clear bready.
  - If bresp[1]=0, pulse wb_ack_o for 1 cycle; otherwise pulse wb_err_o for 1 cycle.
  - Go to DONE.
- READ_REQ: arvalid is held until arready. Then clear arvalid, set rready=1, go to READ_RESP.
- READ_RESP, on rvalid:
  - Clear rready and latch wb_dat_o=rdata.
  - Pulse wb_ack_o, or wb_err_o if rresp[1]=1.
  - Go to DONE.
- DONE: stay until wb_stb_i=0, then go to IDLE. This prevents a held strobe from re-issuing the access.
- Latency with ready-high slave and next-cycle response: write ack is 3 cycles after strobe sampled; read ack is 3 cycles after strobe sampled.
- wb_dat_o holds the last read value until the next read completes.
- Valid signals never drop without a handshake.
- Request fields stay stable while their valid is high.
- Removing cyc/stb mid-transaction does not abort it. The AXI transaction completes, and the ack/err pulse is still issued.

Decomposition:
- Package wb2axi_pkg contains:
  - state enum;
  - AXI constants BURST_INCR=2'b01 and SIZE_4B=3'b010;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - CACHE_DEFAULT=4'b0011.
- No sub-module; a single FSM module.

Test Plan:
- Reset, then write adr 0x0 dat 0xDEADBEEF sel 0xF to a 32-bit AXI BRAM -> awaddr=0, wstrb=0xF, awlen=0, awsize=2, awburst=1, wlast=1, one wb_ack_o pulse, wb_err_o=0.
- Read adr 0x0 -> araddr=0, wb_dat_o=0xDEADBEEF with a single ack.
- Write adr 0x0 dat 0x00000400 sel 0x2, then read 0x0 -> wb_dat_o=0xDEAD04EF.
- Write adr 0x1 dat 0x0000BE00 sel 0x2 -> awaddr=0x0, wstrb=0x2; read 0x0 -> wb_dat_o=0xDEADBEEF.
- Slave holds awready=0 for 3 cycles while wready=1 -> wvalid drops after 1 cycle, awvalid is held 4 cycles, exactly one AW handshake, one ack.
- Slave returns bresp=2'b10 -> wb_err_o pulses 1 cycle, wb_ack_o stays 0; a following read returns rresp=0 normally.

Source files
------------

// File: rtl/wb2axi_pkg.sv
// Shared definitions for the Wishbone classic to AXI4 single-beat bridge.
package wb2axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE_REQ  = 3'd1,
    ST_WRITE_RESP = 3'd2,
    ST_READ_REQ   = 3'd3,
    ST_READ_RESP  = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'b010;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] RESP_SLVERR   = 2'b10;
  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/wb2axi_bridge.sv
// Wishbone B3 classic slave to AXI4 master: one single-beat AXI transaction
// per Wishbone cycle, 32-bit data and address.
module wb2axi_bridge
  import wb2axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [31:0]             wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [31:0]             wb_dat_o,
  output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
  output logic [31:0]             m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
  output logic [31:0]             m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_rid,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  state_e      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic        r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic        r_ack, r_err;

  // A channel counts as finished once its valid is low or handshakes now.
  logic w_aw_fin, w_w_fin;
  assign w_aw_fin = !r_awvalid || m_axi_awready;
  assign w_w_fin  = !r_wvalid  || m_axi_wready;

  logic w_unused;
  assign w_unused = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], m_axi_bid, m_axi_rid,
                      m_axi_rlast, m_axi_bresp[0], m_axi_rresp[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_addr <= {wb_adr_i[31:2], 2'b00};
            if (wb_we_i) begin
              r_wdata   <= wb_dat_i;
              r_wstrb   <= wb_sel_i;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WRITE_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_READ_REQ;
            end
          end
        end
        ST_WRITE_REQ: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_fin && w_w_fin) begin
            r_bready <= 1'b1;
            r_state  <= ST_WRITE_RESP;
          end
        end
        ST_WRITE_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_ack    <= !m_axi_bresp[1];
            r_err    <= m_axi_bresp[1];
            r_state  <= ST_DONE;
          end
        end
        ST_READ_REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_READ_RESP;
          end
        end
        ST_READ_RESP: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= m_axi_rdata;
            r_ack    <= !m_axi_rresp[1];
            r_err    <= m_axi_rresp[1];
            r_state  <= ST_DONE;
          end
        end
        // Wait for the master to drop strobe so a held strobe is not replayed.
        ST_DONE: begin
          if (!wb_stb_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wb_ack_o      = r_ack;
  assign wb_err_o      = r_err;
  assign wb_rty_o      = 1'b0;
  assign wb_dat_o      = r_rdata;

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awcache = CACHE_DEFAULT;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arcache = CACHE_DEFAULT;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_wb2axi_bridge.sv
// Bench for wb2axi_bridge: small AXI BRAM slave model, table of Wishbone
// accesses, scoreboard of expected terminations, plus stall/error/abort cases.
module tb_wb2axi_bridge;

  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]    wb_adr_i, wb_dat_i;
  logic [3:0]     wb_sel_i;
  logic [2:0]     wb_cti_i;
  logic [1:0]     wb_bte_i;
  logic           wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0]    wb_dat_o;
  logic [IDW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [31:0]    m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [7:0]     m_axi_awlen, m_axi_arlen;
  logic [2:0]     m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]     m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic [3:0]     m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_wstrb;
  logic           m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic           m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic           m_axi_rvalid, m_axi_rready, m_axi_rlast;

  wb2axi_bridge #(.AXI_ID_WIDTH(IDW)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- AXI BRAM slave model ----------------
  int          aw_stall_set = 0;
  int          stall_cnt, aw_hs_cnt, w_hs_cnt, ar_hs_cnt, awv_cyc, wv_cyc;
  logic [1:0]  bresp_inj = 2'b00;
  logic [1:0]  rresp_inj = 2'b00;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d, last_awaddr, last_araddr;
  logic [3:0]  w_s, last_wstrb;
  logic [31:0] mem [16];

  assign m_axi_awready = (stall_cnt >= aw_stall_set);
  assign m_axi_wready  = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_bid     = '0;
  assign m_axi_rid     = '0;
  assign m_axi_rlast   = 1'b1;

  logic        aw_now, w_now;
  logic [31:0] a_eff, d_eff;
  logic [3:0]  s_eff;
  assign aw_now = aw_got || (m_axi_awvalid && m_axi_awready);
  assign w_now  = w_got  || (m_axi_wvalid && m_axi_wready);
  assign a_eff  = aw_got ? aw_a : m_axi_awaddr;
  assign d_eff  = w_got ? w_d : m_axi_wdata;
  assign s_eff  = w_got ? w_s : m_axi_wstrb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0; ar_hs_cnt <= 0;
      awv_cyc <= 0; wv_cyc <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0; w_s <= '0;
      last_awaddr <= '0; last_araddr <= '0; last_wstrb <= '0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (m_axi_awvalid) awv_cyc <= awv_cyc + 1;
      if (m_axi_wvalid)  wv_cyc  <= wv_cyc + 1;
      if (m_axi_awvalid && !m_axi_awready) stall_cnt <= stall_cnt + 1;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs_cnt <= aw_hs_cnt + 1; stall_cnt <= 0; last_awaddr <= m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs_cnt <= w_hs_cnt + 1; last_wstrb <= m_axi_wstrb;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (aw_now && w_now) begin
        for (int b = 0; b < 4; b++)
          if (s_eff[b]) mem[a_eff[5:2]][8*b +: 8] <= d_eff[8*b +: 8];
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= bresp_inj;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (m_axi_awvalid && m_axi_awready) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr; end
        if (m_axi_wvalid && m_axi_wready) begin w_got <= 1'b1; w_d <= m_axi_wdata; w_s <= m_axi_wstrb; end
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if (m_axi_arvalid && m_axi_arready) begin
        ar_hs_cnt   <= ar_hs_cnt + 1;
        last_araddr <= m_axi_araddr;
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= mem[m_axi_araddr[5:2]];
        m_axi_rresp  <= rresp_inj;
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rd;
  } exp_t;
  exp_t sbq[$];
  exp_t sb_e;

  localparam logic [31:0] REQ_FIELDS = {4'd0, 4'd0, 8'd0, 3'b010, 2'b01, 4'b0011, 3'd0, 4'd0};

  always @(negedge clk) begin
    if (rst) begin
      if (m_axi_awvalid && m_axi_awready)
        chk("aw_fields", {4'd0, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
                          m_axi_awcache, m_axi_awprot, m_axi_awqos}, REQ_FIELDS);
      if (m_axi_arvalid && m_axi_arready)
        chk("ar_fields", {4'd0, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                          m_axi_arcache, m_axi_arprot, m_axi_arqos}, REQ_FIELDS);
      if (m_axi_wvalid && m_axi_wready) chk("wlast", {31'd0, m_axi_wlast}, 32'd1);
      if (wb_ack_o || wb_err_o) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_term got ack=%b err=%b expected no termination", wb_ack_o, wb_err_o);
        end else begin
          sb_e = sbq.pop_front();
          chk("term_ack_err", {30'd0, wb_ack_o, wb_err_o}, sb_e.err ? 32'd1 : 32'd2);
          chk(sb_e.we ? "dat_hold_on_write" : "read_data", wb_dat_o, sb_e.rd);
          chk("rty", {31'd0, wb_rty_o}, 32'd0);
        end
      end
    end
  end

  task automatic wb_do(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_rd,
                       input int exp_lat, input int drop_after);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    @(negedge clk);
    sbq.push_back('{we, exp_err, exp_rd});
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (wb_ack_o || wb_err_o) done = 1'b1;
      else if (drop_after != 0 && n >= drop_after) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    end
    chk("ack_timeout", {31'd0, done}, 32'd1);
    if (exp_lat != 0) chk("latency", n, exp_lat);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    chk("single_pulse", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rd;
    logic [31:0] axaddr;
    logic [3:0]  strb;
  } vec_t;
  vec_t vt [9];

  initial begin
    int aw0, ar0, awv0, wv0;
    vt[0] = '{1'b1, 32'h0,  32'hDEADBEEF, 4'hF, 32'h0,        32'h0, 4'hF};
    vt[1] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'hDEADBEEF, 32'h0, 4'h0};
    vt[2] = '{1'b1, 32'h0,  32'h00000400, 4'h2, 32'hDEADBEEF, 32'h0, 4'h2};
    vt[3] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'hDEAD04EF, 32'h0, 4'h0};
    vt[4] = '{1'b1, 32'h1,  32'h0000BE00, 4'h2, 32'hDEAD04EF, 32'h0, 4'h2};
    vt[5] = '{1'b0, 32'h0,  32'h0,        4'h0, 32'hDEADBEEF, 32'h0, 4'h0};
    vt[6] = '{1'b1, 32'hA,  32'h12345678, 4'hC, 32'hDEADBEEF, 32'h8, 4'hC};
    vt[7] = '{1'b0, 32'hB,  32'h0,        4'h0, 32'h12340000, 32'h8, 4'h0};
    vt[8] = '{1'b0, 32'h4,  32'h0,        4'h0, 32'h00000000, 32'h4, 4'h0};

    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_dat_i = 0;
    wb_sel_i = 0; wb_cti_i = 3'b111; wb_bte_i = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 32'd0);
    chk("rst_term", {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_addr", m_axi_awaddr, 32'd0);
    chk("rst_wdata", m_axi_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, m_axi_wstrb}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
      wb_do(vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, 1'b0, vt[i].rd, 3, 0);
      if (vt[i].we) begin
        chk("awaddr", last_awaddr, vt[i].axaddr);
        chk("wstrb", {28'd0, last_wstrb}, {28'd0, vt[i].strb});
        chk("aw_count", aw_hs_cnt - aw0, 1);
      end else begin
        chk("araddr", last_araddr, vt[i].axaddr);
        chk("ar_count", ar_hs_cnt - ar0, 1);
      end
    end

    // AW stalled for 3 cycles while W is accepted at once
    aw_stall_set = 3;
    aw0 = aw_hs_cnt; awv0 = awv_cyc; wv0 = wv_cyc;
    wb_do(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 0, 0);
    chk("stall_awvalid_cycles", awv_cyc - awv0, 4);
    chk("stall_wvalid_cycles", wv_cyc - wv0, 1);
    chk("stall_aw_count", aw_hs_cnt - aw0, 1);
    aw_stall_set = 0;

    // write error response, then a normal read
    bresp_inj = 2'b10;
    wb_do(1'b1, 32'h14, 32'h11111111, 4'hF, 1'b1, 32'h0, 3, 0);
    bresp_inj = 2'b00;
    wb_do(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 3, 0);

    // read error still latches the returned data
    rresp_inj = 2'b10;
    wb_do(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 3, 0);
    rresp_inj = 2'b00;

    // strobe removed right after being sampled: access still completes
    wb_do(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h12340000, 3, 1);

    // strobe held long after ack: exactly one AR handshake and one ack
    ar0 = ar_hs_cnt;
    @(negedge clk);
    sbq.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h0;
    repeat (10) @(posedge clk);
    #1;
    wb_cyc_i = 0; wb_stb_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("held_stb_ar_count", ar_hs_cnt - ar0, 1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
